// File: rtl/edf_arbiter.sv
// Earliest-deadline-first arbiter: serially scans pending gateways for the smallest
// deadline, offers the winning ID on a valid/ready handshake and pulses its claim line.
module edf_arbiter #(
    parameter int NrIrqs  = 4,
    parameter int TsWidth = 64,
    localparam int IdWidth = $clog2(NrIrqs)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NrIrqs-1:0]           ip_i,
    input  logic [NrIrqs*TsWidth-1:0]   dl_i,
    output logic [IdWidth-1:0]          irq_id_o,
    output logic                        irq_valid_o,
    input  logic                        irq_ready_i,
    output logic [NrIrqs-1:0]           claim_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_OFFER = 2'd2,
        ST_CLAIM = 2'd3
    } state_e;

    localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrIrqs - 1);

    state_e               r_state;
    logic [IdWidth-1:0]   r_idx;
    logic                 r_best_vld;
    logic [IdWidth-1:0]   r_best_id;
    logic [TsWidth-1:0]   r_best_dl;

    logic [TsWidth-1:0]   w_dl;
    logic                 w_take;
    logic [NrIrqs-1:0]    w_onehot;

    // Candidate evaluation for the index currently under scan; strict less-than keeps ties on the lower ID.
    always_comb begin
        w_dl     = dl_i[r_idx*TsWidth +: TsWidth];
        w_take   = 1'b0;
        w_onehot = {{(NrIrqs-1){1'b0}}, 1'b1} << r_best_id;
        if (ip_i[r_idx] && (!r_best_vld || (w_dl < r_best_dl))) begin
            w_take = 1'b1;
        end else begin
            w_take = 1'b0;
        end
    end

    // Arbitration FSM with registered offer and claim outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_best_vld  <= 1'b0;
            r_best_id   <= '0;
            r_best_dl   <= '0;
            irq_id_o    <= '0;
            irq_valid_o <= 1'b0;
            claim_o     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    claim_o <= '0;
                    if (|ip_i) begin
                        r_state    <= ST_SCAN;
                        r_idx      <= '0;
                        r_best_vld <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_take) begin
                        r_best_vld <= 1'b1;
                        r_best_id  <= r_idx;
                        r_best_dl  <= w_dl;
                    end else begin
                        r_best_vld <= r_best_vld;
                    end
                    // The last index must fold its own candidate into the offer decision.
                    if (r_idx == LastIdx) begin
                        if (r_best_vld || w_take) begin
                            r_state     <= ST_OFFER;
                            irq_valid_o <= 1'b1;
                            irq_id_o    <= w_take ? r_idx : r_best_id;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_idx <= r_idx + IdWidth'(1);
                    end
                end
                ST_OFFER: begin
                    if (irq_ready_i) begin
                        r_state     <= ST_CLAIM;
                        irq_valid_o <= 1'b0;
                        claim_o     <= w_onehot;
                    end else if (!ip_i[r_best_id]) begin
                        r_state     <= ST_IDLE;
                        irq_valid_o <= 1'b0;
                    end else begin
                        r_state <= ST_OFFER;
                    end
                end
                ST_CLAIM: begin
                    claim_o <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    irq_valid_o <= 1'b0;
                    claim_o     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edf_arbiter.sv
// Bench for edf_arbiter: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a sample-and-argmin reference model.
module tb_edf_arbiter;
    localparam int N  = 4;
    localparam int TS = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       ip;
    logic [N*TS-1:0]    dl;
    logic               ready;
    logic [1:0]         irq_id;
    logic               irq_valid;
    logic [N-1:0]       claim;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                 m_mode;   // 0 idle, 1 scanning, 2 offering, 3 claiming
    int                 m_k;
    logic [N-1:0]       s_ip;
    logic [TS-1:0]      s_dl [N];
    logic               m_valid;
    logic [1:0]         m_id;
    logic [N-1:0]       m_claim;

    edf_arbiter #(.NrIrqs(N), .TsWidth(TS)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ip_i        (ip),
        .dl_i        (dl),
        .irq_id_o    (irq_id),
        .irq_valid_o (irq_valid),
        .irq_ready_i (ready),
        .claim_o     (claim)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_k     = 0;
        m_valid = 1'b0;
        m_id    = 2'd0;
        m_claim = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_next();
        int best;
        case (m_mode)
            0: begin
                m_claim = '0;
                if (|ip) begin
                    m_mode = 1;
                    m_k    = 0;
                end
            end
            1: begin
                s_ip[m_k] = ip[m_k];
                s_dl[m_k] = dl[m_k*TS +: TS];
                if (m_k == N-1) begin
                    best = -1;
                    for (int j = 0; j < N; j++) begin
                        if (s_ip[j] && (best < 0 || s_dl[j] < s_dl[best])) best = j;
                    end
                    if (best >= 0) begin
                        m_mode  = 2;
                        m_valid = 1'b1;
                        m_id    = 2'(best);
                    end else begin
                        m_mode = 0;
                    end
                end else begin
                    m_k++;
                end
            end
            2: begin
                if (ready) begin
                    m_mode  = 3;
                    m_valid = 1'b0;
                    m_claim = N'(1) << m_id;
                end else if (!ip[m_id]) begin
                    m_mode  = 0;
                    m_valid = 1'b0;
                end
            end
            default: begin
                m_claim = '0;
                m_mode  = 0;
            end
        endcase
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        chk("valid", irq_valid, m_valid);
        chk("id",    irq_id,    m_id);
        chk("claim", claim,     m_claim);
    endtask

    task automatic set_dl(input int i, input logic [TS-1:0] v);
        dl[i*TS +: TS] = v;
    endtask

    task automatic wait_offer(input int exp_id, input string name);
        int n = 0;
        while (irq_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (irq_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: valid=%b, required 1 within 20 cycles", name, irq_valid);
        end else begin
            chk(name, irq_id, exp_id);
        end
    endtask

    task automatic do_claim(input int id, input string name);
        ready = 1'b1;
        step();
        chk(name, claim, 64'd1 << id);
        ip[id] = 1'b0;
        ready  = 1'b0;
        step();
        chk({name, "_end"}, {claim, irq_valid}, 64'd0);
    endtask

    task automatic count_offer(input int exp_id, input string name);
        repeat (N) step();
        chk({name, "_early"}, irq_valid, 64'd0);
        step();
        chk({name, "_valid"}, irq_valid, 64'd1);
        chk({name, "_id"}, irq_id, exp_id);
    endtask

    initial begin
        rst_n = 1'b0;
        ip    = '0;
        dl    = '0;
        ready = 1'b0;
        model_reset();
        #1;
        chk("rst_outputs", {irq_id, irq_valid, claim}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single line: offer 5 cycles after the IDLE sample
        ip = 4'b0100;
        set_dl(2, 64'd100);
        count_offer(2, "single");
        do_claim(2, "single_claim");

        // EDF select, then next earliest
        ip = 4'b1111;
        set_dl(0, 64'd20); set_dl(1, 64'd30); set_dl(2, 64'd10); set_dl(3, 64'd40);
        wait_offer(2, "edf_first");
        do_claim(2, "edf_claim2");
        wait_offer(0, "edf_second");
        do_claim(0, "edf_claim0");
        ip = '0;
        step();

        // Tie goes to lowest ID
        ip = 4'b1010;
        set_dl(1, 64'd55); set_dl(3, 64'd55);
        wait_offer(1, "tie");
        do_claim(1, "tie_claim1");
        wait_offer(3, "tie_next");
        do_claim(3, "tie_claim3");

        // Withdrawal during scan
        ip = 4'b0001;
        step();
        ip = 4'b0000;
        repeat (N + 2) step();
        chk("scan_withdraw", {irq_valid, claim}, 64'd0);

        // Withdrawal during offer
        ip = 4'b0001;
        set_dl(0, 64'd7);
        wait_offer(0, "offer_wd");
        ip = 4'b0000;
        step();
        chk("offer_wd_drop", {irq_valid, claim}, 64'd0);

        // No preemption while offering
        ip = 4'b1000;
        set_dl(3, 64'd500);
        wait_offer(3, "stable");
        ip[0] = 1'b1;
        set_dl(0, 64'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stable_hold", {irq_valid, irq_id}, {1'b1, 2'd3});
        end
        do_claim(3, "stable_claim3");
        wait_offer(0, "stable_next");
        do_claim(0, "stable_claim0");

        // Asynchronous reset mid-offer
        ip = 4'b0010;
        set_dl(1, 64'd9);
        wait_offer(1, "rst_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {irq_id, irq_valid, claim}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        count_offer(1, "rst_fresh");
        do_claim(1, "rst_claim");

        // Randomized traffic with a gateway emulation
        ip = '0;
        for (int c = 0; c < 3000; c++) begin
            int j;
            ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                j = $urandom_range(0, N-1);
                ip[j] = 1'b1;
                if ($urandom_range(0, 3) == 0) set_dl(j, {$urandom, $urandom});
                else set_dl(j, 64'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 40) == 0) ip[$urandom_range(0, N-1)] = 1'b0;
            if ($urandom_range(0, 20) == 0) set_dl($urandom_range(0, N-1), 64'($urandom_range(0, 15)));
            step();
            ip = ip & ~m_claim;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edf_arbiter.md
# edf_arbiter

Earliest-deadline-first arbiter between the per-line gateway cells and the core's interrupt handshake. It scans the pending flags and deadlines of all `NrIrqs` gateways and selects the pending line with the smallest deadline. It offers that line's ID on a valid/ready interface and returns a one-cycle claim pulse to the selected gateway on acceptance. It replaces the OR-of-pendings valid in the interrupt controller top level.

## Interface
- `NrIrqs`, 4: number of interrupt lines; must be ≥ 2.
- `TsWidth`, 64: deadline/timestamp width in bits.
- `IdWidth` (localparam), `$clog2(NrIrqs)`: width of the interrupt ID.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `ip_i`  in  NrIrqs  pending flag per gateway; bit i belongs to line i.
- `dl_i`  in  NrIrqs*TsWidth  flattened deadlines; line i occupies bits `[i*TsWidth +: TsWidth]`.
- `irq_id_o`  out  IdWidth  ID of the offered line.
- `irq_valid_o`  out  1  offer valid.
- `irq_ready_i`  in  1  core accepts the offer.
- `claim_o`  out  NrIrqs  one-hot claim pulse to the gateways.

## Operation
- Four-state FSM: IDLE, SCAN, OFFER, CLAIM.
- **IDLE**
  - If `|ip_i` is set, go to SCAN with index 0 and the best-valid flag cleared.
  - Otherwise stay in IDLE.
- **SCAN**
  - Examines one index per cycle, from 0 to NrIrqs-1.
  - A candidate at index k qualifies only if `ip_i[k]` is high in the cycle it is examined.
  - It replaces the current best if no best is held yet, or if `dl_i[k]` is strictly less than the best deadline (unsigned, full TsWidth).
  - Ties therefore go to the lowest ID.
  - After index NrIrqs-1:
    - go to OFFER if a best is held;
    - otherwise return to IDLE, because every request was withdrawn during the scan.
  - The index counter is IdWidth bits wide. Termination is detected by comparing against NrIrqs-1, not by counter overflow.
- **OFFER**
  - `irq_valid_o` is high and `irq_id_o` holds the best ID. Both stay stable until the handshake or a withdrawal.
  - Handshake: if `irq_valid_o & irq_ready_i`, go to CLAIM.
  - Withdrawal: if `ip_i[best]` is low and `irq_ready_i` is low, go to IDLE.
  - If ready and withdrawal occur in the same cycle, the handshake wins and the claim is still issued.
  - Lines that become pending, or whose deadlines change, while in OFFER do not preempt the offer. They are considered at the next scan.
- **CLAIM**
  - `claim_o[best]` is high for exactly this one cycle; all other bits are 0.
  - Then go to IDLE.
  - The gateway clears its pending flag on the claim. IDLE samples `ip_i` one cycle later.
- `irq_ready_i` is ignored outside OFFER.
- `irq_id_o` retains its last value outside OFFER. Consumers qualify it with `irq_valid_o`.

## Timing
- Reset values while `rst_ni` is low:
  - state = IDLE;
  - `irq_valid_o` = 0, `irq_id_o` = 0, `claim_o` = 0;
  - best-valid flag = 0, index = 0, best deadline = 0.
- All outputs are registered.
- Reset asserted mid-operation (SCAN, OFFER or CLAIM) aborts immediately.
  - No claim is emitted for an offer lost to reset.
- Latency and throughput:
  - Pending flag seen in IDLE at cycle t: SCAN runs t+1 … t+NrIrqs, and `irq_valid_o` rises at t+NrIrqs+1.
  - Handshake at cycle h: `claim_o` is high at h+1, and state is IDLE at h+2.
  - Back-to-back claims are therefore at least NrIrqs+3 cycles apart.
- Deadline comparison is plain unsigned. Wrap-around of `mtime` is not compensated by this block.

## Test plan
- **Single line.** NrIrqs=4; `ip_i`=0b0100, dl[2]=100 → valid rises 5 cycles after IDLE sample with ID=2. With ready held high: `claim_o`=0b0100 for one cycle, then valid=0.
- **EDF select.** `ip_i`=0b1111; dl = {40, 10, 30, 20} for IDs 3..0 → ID=2 offered. After its claim and the drop of ip[2], the next offer is ID=0 (dl=20).
- **Tie.** ip[1] and ip[3] set, both dl=55 → ID=1 offered.
- **Withdrawal.**
  - During SCAN: ip[0] drops before index 0 is examined and is the only request → no offer, return to IDLE.
  - During OFFER: ip[id] drops with ready low → valid falls the next cycle and `claim_o` stays 0.
- **Stability / no preemption.** Offer ID=3 (dl=500) held with ready low for 10 cycles while ip[0] rises with dl=5 → `irq_id_o` stays 3 and valid stays high. After ready and the claim of ID=3, the next offer is ID=0.
- **Reset mid-OFFER.** Deassert `rst_ni` asynchronously while valid=1 → valid, ID and `claim_o` go to 0 at once. After release with `ip_i` still set, a fresh scan produces a new offer NrIrqs+1 cycles after IDLE.
